// File: rtl/vga_sync_if.sv
// -----------------------------------------------------------------------------
// vga_sync_if
//   Raster-timing bundle from the VGA sync generator to the renderers, the
//   final pixel mux and the VGA connector.
//
//   Signals:
//     p_tick       one-clk pulse on the last clk of each pixel slot
//     x            current column, 0..H_TOTAL-1
//     y            current line,   0..V_TOTAL-1
//     hsync        horizontal sync, active low
//     vsync        vertical sync, active low
//     video_on     high inside the visible window
//     frame_start  one-clk pulse; the next pixel is (0,0)
//
//   Modports:
//     master  the timing generator (drives everything)
//     slave   renderers / pixel mux / connector (observe everything)
// -----------------------------------------------------------------------------
interface vga_sync_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;

  modport master (
    output p_tick,
    output x,
    output y,
    output hsync,
    output vsync,
    output video_on,
    output frame_start
  );

  modport slave (
    input p_tick,
    input x,
    input y,
    input hsync,
    input vsync,
    input video_on,
    input frame_start
  );
endinterface : vga_sync_if

// File: rtl/vga_sync.sv
// -----------------------------------------------------------------------------
// vga_sync
//   Raster timing generator for the pong display pipeline. Divides clk down
//   to the pixel rate, walks the x/y raster and produces registered
//   hsync/vsync/video_on that always line up with the x/y on the ports.
//   Default timing is 640x480@60 Hz from a 100 MHz clk.
//
//   Ports:
//     clk     in   system clock, the only clock in the block
//     reset   in   synchronous, active-high reset
//     o_vga   vga_sync_if.master: p_tick, x, y, hsync, vsync, video_on,
//             frame_start
//
//   Parameters:
//     CLK_DIV                               clk cycles per pixel (>=1)
//     H_DISPLAY/H_FRONT/H_SYNC/H_BACK       horizontal timing, in pixels
//     V_DISPLAY/V_FRONT/V_SYNC/V_BACK       vertical timing, in lines
//   H_TOTAL and V_TOTAL must not exceed 1024 (10-bit unsigned counters).
// -----------------------------------------------------------------------------
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master o_vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // A one-bit divider is kept for CLK_DIV=1 so the width never collapses to 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // ---------------------------------------------------------------------------
  // Raster decode helpers (all compares unsigned at 10 bits)
  // ---------------------------------------------------------------------------

  // hsync level (active low) for a given column
  function automatic logic f_hsync_level(input logic [9:0] i_x);
    return !((i_x >= HS_START) && (i_x <= HS_END));
  endfunction

  // vsync level (active low) for a given line
  function automatic logic f_vsync_level(input logic [9:0] i_y);
    return !((i_y >= VS_START) && (i_y <= VS_END));
  endfunction

  // visible-window flag for a given pixel position
  function automatic logic f_video_on(input logic [9:0] i_x,
                                      input logic [9:0] i_y);
    return (i_x < X_VIS) && (i_y < Y_VIS);
  endfunction

  // ---------------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;

  logic [DIV_W-1:0] w_div_nxt;
  logic [9:0]       w_x_nxt;
  logic [9:0]       w_y_nxt;
  logic             w_p_tick;
  logic             w_line_end;
  logic             w_frame_end;
  logic             w_frame_start;

  // p_tick is masked while reset is asserted: with CLK_DIV=1 the divider sits
  // permanently on its last value, and a reset landing on the frame wrap must
  // not leak a frame_start pulse.
  assign w_p_tick      = !reset && (r_div == DIV_LAST);
  assign w_line_end    = (r_x == X_LAST);
  assign w_frame_end   = (r_y == Y_LAST);
  assign w_frame_start = w_p_tick && w_line_end && w_frame_end;

  // Pixel-rate divider next state: 0..CLK_DIV-1 then wrap
  always_comb begin
    w_div_nxt = r_div;
    if (r_div == DIV_LAST) begin
      w_div_nxt = DIV_ZERO;
    end else begin
      w_div_nxt = r_div + DIV_ONE;
    end
  end

  // Raster counter next state: advance only on the last clk of a pixel slot
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_p_tick) begin
      if (w_line_end) begin
        w_x_nxt = 10'd0;
        if (w_frame_end) begin
          w_y_nxt = 10'd0;
        end else begin
          w_y_nxt = r_y + 10'd1;
        end
      end else begin
        w_x_nxt = r_x + 10'd1;
      end
    end else begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
    end
  end

  // Counter and sync registers; syncs are decoded from the next-state x/y so
  // they change on the same edge as the counters they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= DIV_ZERO;
      r_x        <= 10'd0;
      r_y        <= 10'd0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b1;
    end else begin
      r_div      <= w_div_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_hsync    <= f_hsync_level(w_x_nxt);
      r_vsync    <= f_vsync_level(w_y_nxt);
      r_video_on <= f_video_on(w_x_nxt, w_y_nxt);
    end
  end

  // ---------------------------------------------------------------------------
  // Interface outputs
  // ---------------------------------------------------------------------------
  assign o_vga.p_tick      = w_p_tick;
  assign o_vga.x           = r_x;
  assign o_vga.y           = r_y;
  assign o_vga.hsync       = r_hsync;
  assign o_vga.vsync       = r_vsync;
  assign o_vga.video_on    = r_video_on;
  assign o_vga.frame_start = w_frame_start;

endmodule : vga_sync

// File: tb/tb_vga_sync.sv
// -----------------------------------------------------------------------------
// tb_vga_sync
//   Bench for vga_sync. Two instances share one clock: the default 640x480
//   timing (CLK_DIV=4) and a tiny raster (CLK_DIV=1, H 8/1/2/1, V 4/1/1/1,
//   i.e. 12 x 7) so that whole frames fit in a short run.
// -----------------------------------------------------------------------------
module tb_vga_sync;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_sync_if vga ();
  vga_sync_if vga_s ();

  vga_sync dut (
    .clk   (clk),
    .reset (rst),
    .o_vga (vga)
  );

  vga_sync #(
    .CLK_DIV   (1),
    .H_DISPLAY (8),
    .H_FRONT   (1),
    .H_SYNC    (2),
    .H_BACK    (1),
    .V_DISPLAY (4),
    .V_FRONT   (1),
    .V_SYNC    (1),
    .V_BACK    (1)
  ) dut_s (
    .clk   (clk),
    .reset (rst_s),
    .o_vga (vga_s)
  );

  // Compare one observed value against its expected value
  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clk and land 1 ns after the falling edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int pix, ex, ey, ep, ehs, evs, evid, efs;
    int hs_ticks, hs_first, fs_cnt, n;

    rst      = 1'b1;
    rst_s    = 1'b1;
    hs_ticks = 0;
    hs_first = -1;
    fs_cnt   = 0;

    // Reset held for 3 clks
    repeat (3) @(posedge clk);
    step();
    check_eq("rst_x",        int'(vga.x), 0);
    check_eq("rst_y",        int'(vga.y), 0);
    check_eq("rst_p_tick",   int'(vga.p_tick), 0);
    check_eq("rst_fs",       int'(vga.frame_start), 0);
    check_eq("rst_hsync",    int'(vga.hsync), 1);
    check_eq("rst_vsync",    int'(vga.vsync), 1);
    check_eq("rst_video_on", int'(vga.video_on), 1);
    check_eq("rst_s_p_tick", int'(vga_s.p_tick), 0);
    check_eq("rst_s_fs",     int'(vga_s.frame_start), 0);

    // Default instance: release and walk one full line plus a bit of the next
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3210; k++) begin
      pix  = k / 4;
      ex   = pix % 800;
      ey   = pix / 800;
      ep   = ((k % 4) == 3) ? 1 : 0;
      ehs  = (ex >= 656 && ex <= 751) ? 0 : 1;
      evid = (ex < 640 && ey < 480) ? 1 : 0;
      check_eq("x",           int'(vga.x), ex);
      check_eq("y",           int'(vga.y), ey);
      check_eq("p_tick",      int'(vga.p_tick), ep);
      check_eq("hsync",       int'(vga.hsync), ehs);
      check_eq("vsync",       int'(vga.vsync), 1);
      check_eq("video_on",    int'(vga.video_on), evid);
      check_eq("frame_start", int'(vga.frame_start), 0);
      if (ey == 0 && vga.p_tick && !vga.hsync) begin
        if (hs_ticks == 0) hs_first = int'(vga.x);
        hs_ticks++;
      end
      step();
    end
    check_eq("hsync_low_ticks", hs_ticks, 96);
    check_eq("hsync_first_x",   hs_first, 656);

    // Mid-line reset at x=700 of line 1 while hsync is low
    n = 0;
    while (int'(vga.x) != 700 && n < 4000) begin
      step();
      n++;
    end
    check_eq("wait_x700", (n < 4000) ? 1 : 0, 1);
    check_eq("pre_rst_hsync", int'(vga.hsync), 0);
    check_eq("pre_rst_y",     int'(vga.y), 1);
    rst = 1'b1;
    #1;
    check_eq("in_rst_p_tick", int'(vga.p_tick), 0);
    check_eq("in_rst_fs",     int'(vga.frame_start), 0);
    step();
    check_eq("mid_rst_x",        int'(vga.x), 0);
    check_eq("mid_rst_y",        int'(vga.y), 0);
    check_eq("mid_rst_hsync",    int'(vga.hsync), 1);
    check_eq("mid_rst_vsync",    int'(vga.vsync), 1);
    check_eq("mid_rst_video_on", int'(vga.video_on), 1);
    check_eq("mid_rst_fs",       int'(vga.frame_start), 0);
    rst = 1'b0;
    #1;
    // First pixel slot after reset lasts exactly 4 clks
    for (int k = 0; k < 5; k++) begin
      check_eq("post_rst_x",      int'(vga.x), (k < 4) ? 0 : 1);
      check_eq("post_rst_p_tick", int'(vga.p_tick), (k == 3) ? 1 : 0);
      step();
    end

    // Small instance: CLK_DIV=1, 12 x 7 raster, two full frames
    check_eq("s_rst_p_tick", int'(vga_s.p_tick), 0);
    rst_s = 1'b0;
    #1;
    for (int k = 0; k < 174; k++) begin
      ex   = k % 12;
      ey   = (k / 12) % 7;
      ehs  = (ex >= 9 && ex <= 10) ? 0 : 1;
      evs  = (ey == 5) ? 0 : 1;
      evid = (ex < 8 && ey < 4) ? 1 : 0;
      efs  = (ex == 11 && ey == 6) ? 1 : 0;
      check_eq("s_x",           int'(vga_s.x), ex);
      check_eq("s_y",           int'(vga_s.y), ey);
      check_eq("s_p_tick",      int'(vga_s.p_tick), 1);
      check_eq("s_hsync",       int'(vga_s.hsync), ehs);
      check_eq("s_vsync",       int'(vga_s.vsync), evs);
      check_eq("s_video_on",    int'(vga_s.video_on), evid);
      check_eq("s_frame_start", int'(vga_s.frame_start), efs);
      if (vga_s.frame_start) fs_cnt++;
      step();
    end
    check_eq("s_frame_count", fs_cnt, 2);

    // Reset landing exactly on the frame wrap must suppress frame_start
    n = 0;
    while (!(int'(vga_s.x) == 11 && int'(vga_s.y) == 6) && n < 200) begin
      step();
      n++;
    end
    check_eq("wait_wrap_s", (n < 200) ? 1 : 0, 1);
    rst_s = 1'b1;
    #1;
    check_eq("s_wrap_rst_fs",     int'(vga_s.frame_start), 0);
    check_eq("s_wrap_rst_p_tick", int'(vga_s.p_tick), 0);
    step();
    check_eq("s_rst_x",        int'(vga_s.x), 0);
    check_eq("s_rst_y",        int'(vga_s.y), 0);
    check_eq("s_rst_hsync",    int'(vga_s.hsync), 1);
    check_eq("s_rst_vsync",    int'(vga_s.vsync), 1);
    check_eq("s_rst_video_on", int'(vga_s.video_on), 1);
    rst_s = 1'b0;
    #1;
    check_eq("s_post_rst_p_tick", int'(vga_s.p_tick), 1);
    check_eq("s_post_rst_x0",     int'(vga_s.x), 0);
    step();
    check_eq("s_post_rst_x1",     int'(vga_s.x), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vga_sync
